// File: rtl/imgproc_msg_reader_if.sv
// Avalon-MM master/slave bundle between the message reader and the image processor.
interface imgproc_msg_reader_if;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_chipselect, m_read, m_write, m_address, m_writedata,
        input  m_readdata
    );
    modport slave (
        input  m_chipselect, m_read, m_write, m_address, m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/imgproc_msg_reader.sv
// Hardware drain of the image processor bounding-box FIFO: polls status, reads
// 3-word messages and holds the latest box per colour for the steering logic.
module imgproc_msg_reader #(
    parameter int POLL_INTERVAL = 1000,
    parameter int IMAGE_W       = 640,
    parameter int IMAGE_H       = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    imgproc_msg_reader_if.master mm,
    output logic [43:0]          box_red,
    output logic [43:0]          box_blue,
    output logic [43:0]          box_yellow,
    output logic [43:0]          box_white,
    output logic [3:0]           box_present,
    output logic                 box_upd,
    output logic [1:0]           box_upd_col,
    output logic [7:0]           err_count
);
    localparam int              TW     = $clog2(POLL_INTERVAL);
    localparam logic [TW-1:0]   RELOAD = TW'(POLL_INTERVAL - 1);
    localparam logic [11:0]     W_LIM  = 12'(IMAGE_W);
    localparam logic [11:0]     H_LIM  = 12'(IMAGE_H);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_STAT, S_WT_STAT, S_RD_ID, S_WT_ID, S_RD_MIN,
        S_WT_MIN, S_RD_MAX, S_WT_MAX, S_COMMIT, S_FLUSH
    } state_t;

    state_t         r_state, w_next;
    logic [TW-1:0]  r_timer;
    logic [1:0]     r_col;
    logic [10:0]    r_xmin, r_ymin, r_xmax, r_ymax;
    logic [43:0]    r_box [4];
    logic [3:0]     r_present;
    logic           r_upd;
    logic [1:0]     r_upd_col;
    logic [7:0]     r_err;

    logic           w_rd, w_wr;
    logic [2:0]     w_addr;
    logic           w_id_ok;
    logic           w_present;
    logic [7:0]     w_words;

    assign w_words   = mm.m_readdata[15:8];
    assign w_id_ok   = (mm.m_readdata != 32'd0) && (mm.m_readdata <= 32'd4);
    assign w_present = (r_xmin <= r_xmax) && ({1'b0, r_xmax} < W_LIM) &&
                       (r_ymin <= r_ymax) && ({1'b0, r_ymax} < H_LIM);

    // Every RD_* state is followed by a WT_* state, so reads are never adjacent.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = 3'd0;
        case (r_state)
            S_IDLE:    if (r_timer == '0 && enable) w_next = S_RD_STAT;
            S_RD_STAT: begin w_rd = 1'b1; w_next = S_WT_STAT; end
            S_WT_STAT: w_next = (w_words >= 8'd3) ? S_RD_ID : S_IDLE;
            S_RD_ID:   begin w_rd = 1'b1; w_addr = 3'd1; w_next = S_WT_ID; end
            S_WT_ID:   w_next = w_id_ok ? S_RD_MIN : S_FLUSH;
            S_RD_MIN:  begin w_rd = 1'b1; w_addr = 3'd1; w_next = S_WT_MIN; end
            S_WT_MIN:  w_next = S_RD_MAX;
            S_RD_MAX:  begin w_rd = 1'b1; w_addr = 3'd1; w_next = S_WT_MAX; end
            S_WT_MAX:  w_next = S_COMMIT;
            S_COMMIT:  w_next = enable ? S_RD_STAT : S_IDLE;
            S_FLUSH:   begin w_wr = 1'b1; w_next = S_IDLE; end
            default:   w_next = S_IDLE;
        endcase
    end

    assign mm.m_read       = w_rd;
    assign mm.m_write      = w_wr;
    assign mm.m_chipselect = w_rd | w_wr;
    assign mm.m_address    = w_addr;
    assign mm.m_writedata  = w_wr ? 32'h0000_0010 : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= RELOAD;
            r_col     <= 2'd0;
            r_present <= 4'd0;
            r_upd     <= 1'b0;
            r_upd_col <= 2'd0;
            r_err     <= 8'd0;
            for (int i = 0; i < 4; i++) r_box[i] <= 44'd0;
        end else begin
            r_state <= w_next;
            r_upd   <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_next == S_RD_STAT)  r_timer <= RELOAD;
                else if (r_timer != '0)   r_timer <= r_timer - 1'b1;
            end
            if (r_state == S_WT_ID) begin
                if (w_id_ok)              r_col <= mm.m_readdata[1:0] - 2'd1;
                else if (r_err != 8'hFF)  r_err <= r_err + 8'd1;
            end
            // Single commit point keeps each box word consistent for the consumer.
            if (r_state == S_COMMIT) begin
                r_box[r_col]     <= {r_xmin, r_ymin, r_xmax, r_ymax};
                r_present[r_col] <= w_present;
                r_upd            <= 1'b1;
                r_upd_col        <= r_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_WT_MIN) begin
            r_xmin <= mm.m_readdata[26:16];
            r_ymin <= mm.m_readdata[10:0];
        end
        if (r_state == S_WT_MAX) begin
            r_xmax <= mm.m_readdata[26:16];
            r_ymax <= mm.m_readdata[10:0];
        end
    end

    assign box_red     = r_box[0];
    assign box_blue    = r_box[1];
    assign box_yellow  = r_box[2];
    assign box_white   = r_box[3];
    assign box_present = r_present;
    assign box_upd     = r_upd;
    assign box_upd_col = r_upd_col;
    assign err_count   = r_err;
endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader with a behavioural message-FIFO slave.
module tb_imgproc_msg_reader;
    localparam int PI = 20;
    localparam logic [43:0] RED_BOX   = {11'd100, 11'd50, 11'd200, 11'd150};
    localparam logic [43:0] BLUE_BOX  = {11'd10, 11'd20, 11'd30, 11'd40};
    localparam logic [43:0] WHITE_BOX = {11'd0, 11'd0, 11'd639, 11'd479};
    localparam logic [43:0] YEL_BOX   = {11'd639, 11'd479, 11'd0, 11'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    imgproc_msg_reader_if mm();
    logic [43:0] box_red, box_blue, box_yellow, box_white;
    logic [3:0]  box_present;
    logic        box_upd;
    logic [1:0]  box_upd_col;
    logic [7:0]  err_count;

    imgproc_msg_reader #(.POLL_INTERVAL(PI), .IMAGE_W(640), .IMAGE_H(480)) dut (
        .clk(clk), .reset(rst), .enable(enable), .mm(mm),
        .box_red(box_red), .box_blue(box_blue), .box_yellow(box_yellow), .box_white(box_white),
        .box_present(box_present), .box_upd(box_upd), .box_upd_col(box_upd_col),
        .err_count(err_count)
    );

    logic [31:0] mem [16];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    logic        flush_req = 1'b0;

    int total = 0, bad = 0;
    int cyc = 0, rd_cnt = 0, rd1_cnt = 0, st_cnt = 0, wr_cnt = 0, wr_ok = 0;
    int upd_cnt = 0, viol = 0, cs_bad = 0;
    int st_last = 0, st_prev = 0, upd_last = 0, upd_prev = 0;
    logic [1:0] upd_col_last = 2'd0;
    logic       prev_rd = 1'b0;

    // Slave: status reports fill level in [15:8]; address 1 pops; 0x10 write to address 0 flushes.
    always @(posedge clk) begin
        if (mm.m_read && mm.m_address == 3'd0) mm.m_readdata <= {16'd0, wp - rp, 8'd0};
        else if (mm.m_read)                    mm.m_readdata <= mem[rp[3:0]];
        else                                   mm.m_readdata <= 32'hDEAD_BEEF;
        if (flush_req || (mm.m_write && mm.m_address == 3'd0 && mm.m_writedata == 32'h10))
            rp <= wp;
        else if (mm.m_read && mm.m_address == 3'd1)
            rp <= rp + 8'd1;
    end

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_rd <= mm.m_read;
        if (mm.m_read && prev_rd) viol <= viol + 1;
        if (mm.m_chipselect !== (mm.m_read | mm.m_write)) cs_bad <= cs_bad + 1;
        if (mm.m_read) begin
            rd_cnt <= rd_cnt + 1;
            if (mm.m_address == 3'd1) rd1_cnt <= rd1_cnt + 1;
            else begin st_cnt <= st_cnt + 1; st_prev <= st_last; st_last <= cyc; end
        end
        if (mm.m_write) begin
            wr_cnt <= wr_cnt + 1;
            if (mm.m_address == 3'd0 && mm.m_writedata == 32'h10) wr_ok <= wr_ok + 1;
        end
        if (box_upd) begin
            upd_cnt <= upd_cnt + 1; upd_col_last <= box_upd_col;
            upd_prev <= upd_last; upd_last <= cyc;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[wp[3:0]] = w;
        wp = wp + 8'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({mm.m_read, mm.m_write, mm.m_chipselect} !== 3'b000) begin bad++;
            $display("FAIL reset_bus: rd/wr/cs=%b expected 000", {mm.m_read, mm.m_write, mm.m_chipselect}); end
        total++; if ({box_red, box_blue, box_yellow, box_white} !== 176'd0) begin bad++;
            $display("FAIL reset_boxes: got %h expected 0", {box_red, box_blue, box_yellow, box_white}); end
        total++; if ({box_present, box_upd, box_upd_col, err_count} !== 15'd0) begin bad++;
            $display("FAIL reset_status: got %h expected 0", {box_present, box_upd, box_upd_col, err_count}); end
        rst = 1'b0;
    endtask

    task automatic test_single_msg();
        int b_rd, b_rd1, b_upd;
        b_rd = rd_cnt; b_rd1 = rd1_cnt; b_upd = upd_cnt;
        push(32'd1); push(32'h0064_0032); push(32'h00C8_0096);
        enable = 1'b1;
        for (int i = 0; i < 100 && rd_cnt == b_rd; i++) begin @(posedge clk); #1; end
        enable = 1'b0;
        for (int i = 0; i < 50 && upd_cnt == b_upd; i++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        total++; if (box_red !== RED_BOX) begin bad++;
            $display("FAIL single_box_red: got %h expected %h", box_red, RED_BOX); end
        total++; if (box_present !== 4'b0001) begin bad++;
            $display("FAIL single_present: got %b expected 0001", box_present); end
        total++; if (upd_cnt - b_upd !== 1 || upd_col_last !== 2'd0) begin bad++;
            $display("FAIL single_upd: count %0d col %0d expected 1 col 0", upd_cnt - b_upd, upd_col_last); end
        total++; if (rd_cnt - b_rd !== 4 || rd1_cnt - b_rd1 !== 3) begin bad++;
            $display("FAIL single_reads: total %0d addr1 %0d expected 4/3", rd_cnt - b_rd, rd1_cnt - b_rd1); end
    endtask

    task automatic test_back_to_back();
        int b_rd, b_rd1, b_upd;
        b_rd = rd_cnt; b_rd1 = rd1_cnt; b_upd = upd_cnt;
        push(32'd2); push(32'h000A_0014); push(32'h001E_0028);
        push(32'd4); push(32'h0000_0000); push(32'h027F_01DF);
        enable = 1'b1;
        for (int i = 0; i < 200 && upd_cnt < b_upd + 2; i++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        total++; if (upd_cnt - b_upd !== 2 || upd_col_last !== 2'd3) begin bad++;
            $display("FAIL b2b_upd: count %0d last col %0d expected 2 col 3", upd_cnt - b_upd, upd_col_last); end
        total++; if (upd_last - upd_prev !== 9) begin bad++;
            $display("FAIL b2b_gap: %0d cycles between commits expected 9", upd_last - upd_prev); end
        total++; if (box_blue !== BLUE_BOX || box_white !== WHITE_BOX || box_red !== RED_BOX) begin bad++;
            $display("FAIL b2b_boxes: blue %h white %h red %h expected %h %h %h",
                     box_blue, box_white, box_red, BLUE_BOX, WHITE_BOX, RED_BOX); end
        total++; if (box_present !== 4'b1011) begin bad++;
            $display("FAIL b2b_present: got %b expected 1011", box_present); end
        total++; if (rd_cnt - b_rd !== 9 || rd1_cnt - b_rd1 !== 6) begin bad++;
            $display("FAIL b2b_reads: total %0d addr1 %0d expected 9/6", rd_cnt - b_rd, rd1_cnt - b_rd1); end
    endtask

    task automatic test_bad_id();
        int b_rd, b_rd1, b_upd, b_wr, b_ok;
        b_rd = rd_cnt; b_rd1 = rd1_cnt; b_upd = upd_cnt; b_wr = wr_cnt; b_ok = wr_ok;
        push(32'd7); push(32'h1111_1111); push(32'h2222_2222);
        enable = 1'b1;
        for (int i = 0; i < 100 && wr_cnt == b_wr; i++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (err_count !== 8'd1) begin bad++;
            $display("FAIL badid_err: got %0d expected 1", err_count); end
        total++; if (wr_cnt - b_wr !== 1 || wr_ok - b_ok !== 1) begin bad++;
            $display("FAIL badid_flush: writes %0d good %0d expected 1/1", wr_cnt - b_wr, wr_ok - b_ok); end
        total++; if (upd_cnt !== b_upd || rd_cnt - b_rd !== 2 || rd1_cnt - b_rd1 !== 1) begin bad++;
            $display("FAIL badid_traffic: upd %0d reads %0d addr1 %0d expected 0/2/1",
                     upd_cnt - b_upd, rd_cnt - b_rd, rd1_cnt - b_rd1); end
        total++; if (box_red !== RED_BOX || box_blue !== BLUE_BOX || box_white !== WHITE_BOX ||
                     box_yellow !== 44'd0 || box_present !== 4'b1011) begin bad++;
            $display("FAIL badid_boxes: boxes changed, present %b expected 1011", box_present); end
    endtask

    task automatic test_empty_box();
        int b_upd;
        b_upd = upd_cnt;
        push(32'd3); push(32'h027F_01DF); push(32'h0000_0000);
        enable = 1'b1;
        for (int i = 0; i < 100 && upd_cnt == b_upd; i++) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (box_yellow !== YEL_BOX) begin bad++;
            $display("FAIL empty_box: got %h expected %h", box_yellow, YEL_BOX); end
        total++; if (box_present !== 4'b1011 || upd_col_last !== 2'd2 || upd_cnt - b_upd !== 1) begin bad++;
            $display("FAIL empty_present: present %b col %0d upd %0d expected 1011 2 1",
                     box_present, upd_col_last, upd_cnt - b_upd); end
    endtask

    task automatic test_short_fifo();
        int b_st, b_rd1, b_upd;
        b_st = st_cnt; b_rd1 = rd1_cnt; b_upd = upd_cnt;
        push(32'h55); push(32'h66);
        enable = 1'b1;
        for (int i = 0; i < 200 && st_cnt < b_st + 3; i++) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (st_cnt - b_st !== 3 || st_last - st_prev !== PI + 2) begin bad++;
            $display("FAIL short_poll: polls %0d interval %0d expected 3 and %0d",
                     st_cnt - b_st, st_last - st_prev, PI + 2); end
        total++; if (rd1_cnt !== b_rd1 || upd_cnt !== b_upd) begin bad++;
            $display("FAIL short_no_msg: addr1 reads %0d upd %0d expected 0/0", rd1_cnt - b_rd1, upd_cnt - b_upd); end
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
    endtask

    task automatic test_reset_mid_msg();
        int b_rd1, b_st, b_upd, n;
        b_rd1 = rd1_cnt;
        push(32'd1); push(32'h0001_0002); push(32'h0003_0004);
        enable = 1'b1;
        for (int i = 0; i < 100 && rd1_cnt < b_rd1 + 2; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        total++; if ({mm.m_read, mm.m_chipselect, box_upd} !== 3'b000 || box_present !== 4'd0 || err_count !== 8'd0) begin bad++;
            $display("FAIL midrst_ctrl: rd/cs/upd %b present %b err %0d expected 0",
                     {mm.m_read, mm.m_chipselect, box_upd}, box_present, err_count); end
        total++; if ({box_red, box_blue, box_yellow, box_white} !== 176'd0) begin bad++;
            $display("FAIL midrst_boxes: got %h expected 0", {box_red, box_blue, box_yellow, box_white}); end
        @(posedge clk);
        #1;
        rst = 1'b0; flush_req = 1'b1;
        b_st = st_cnt; b_upd = upd_cnt; n = 0;
        while (n < 100 && st_cnt == b_st) begin @(posedge clk); #1; flush_req = 1'b0; n++; end
        total++; if (n !== PI + 1) begin bad++;
            $display("FAIL midrst_poll: first poll after %0d cycles expected %0d", n, PI + 1); end
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        total++; if (upd_cnt !== b_upd || box_red !== 44'd0) begin bad++;
            $display("FAIL midrst_discard: upd %0d red %h expected 0/0", upd_cnt - b_upd, box_red); end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_back_to_back();
        test_bad_id();
        test_empty_box();
        test_short_fifo();
        test_reset_mid_msg();
        total++; if (viol !== 0) begin bad++;
            $display("FAIL read_spacing: %0d back-to-back reads expected 0", viol); end
        total++; if (cs_bad !== 0) begin bad++;
            $display("FAIL chipselect: %0d bad cycles expected 0", cs_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
